// File: rtl/fifo_push_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO push arbiter.
//   arb_state_t : controller state (RUN accepts pushes, FLUSH drains the FIFO)
//   cnt_w()     : width of the occupancy counter, enough to hold 0..DEPTH
package fifo_arb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } arb_state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: bundles the requester side, the consumer pop request,
// the FIFO control/status pair and the arbiter status outputs.
//   master : environment side (drives requests, pop_req, flush, FIFO status)
//   slave  : arbiter side (drives grants, FIFO controls, cnt, status, state)
//
// Handshake: req[i] is a level request; a push happens in exactly the cycle
// where gnt[i] is high (gnt is one-hot, and only high when fifo_push is high),
// so gnt doubles as the per-requester "ready". fifo_push/fifo_pop are single
// cycle strobes to the FIFO, qualified by its fifo_full/fifo_empty status.
interface fifo_push_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NREQ  = 4
);
    import fifo_arb_pkg::*;

    localparam int CW = cnt_w(DEPTH);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  pop_req;
    logic                  flush;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [WIDTH-1:0]      fifo_data_in;
    logic [CW-1:0]         cnt;
    logic                  flush_done;
    logic                  status_err;
    arb_state_t            state;

    modport master (
        output req, req_data, pop_req, flush, fifo_full, fifo_empty,
        input  gnt, fifo_push, fifo_pop, fifo_data_in, cnt, flush_done,
               status_err, state
    );

    modport slave (
        input  req, req_data, pop_req, flush, fifo_full, fifo_empty,
        output gnt, fifo_push, fifo_pop, fifo_data_in, cnt, flush_done,
               status_err, state
    );

endinterface

// File: rtl/fifo_push_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req   : request vector
//   ptr   : index where the search starts
//   gnt   : one-hot winner (0 when nothing requests)
//   idx   : binary index of the winner
//   valid : some requester won
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        // Walk NREQ positions starting at ptr; the first requester seen wins.
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin push arbiter in front of a FIFO, with
// occupancy tracking, FIFO status cross-check and a flush (drain) mode.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_push_arbiter_if slave modport (requests, grants, FIFO
//              controls/status, cnt, flush_done, status_err, state)
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NREQ  = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_push_arbiter_if.slave bus
);

    localparam int            CW      = cnt_w(DEPTH);
    localparam int            PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [PW-1:0] IDX_MAX = PW'(NREQ - 1);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          flush_done;
    logic          status_err;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_valid;
    logic            push;
    logic            pop;
    logic            status_bad;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req   (bus.req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // rst gates the controls directly so nothing leaks out while reset is held.
    assign push = !rst && (state == RUN) && arb_valid && !bus.fifo_full;
    assign pop  = !rst && ((state == RUN) ? (bus.pop_req && !bus.fifo_empty)
                                          : !bus.fifo_empty);

    assign status_bad = (bus.fifo_empty != (cnt == '0)) ||
                        (bus.fifo_full  != (cnt == CNT_MAX));

    assign bus.gnt          = push ? arb_gnt : '0;
    assign bus.fifo_push    = push;
    assign bus.fifo_pop     = pop;
    assign bus.fifo_data_in = push ? bus.req_data[int'(arb_idx)*WIDTH +: WIDTH] : '0;
    assign bus.cnt          = cnt;
    assign bus.flush_done   = flush_done;
    assign bus.status_err   = status_err;
    assign bus.state        = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            ptr        <= '0;
            cnt        <= '0;
            flush_done <= 1'b0;
            status_err <= 1'b0;
        end else begin
            flush_done <= 1'b0;

            if (status_bad)
                status_err <= 1'b1;

            if (push)
                ptr <= (arb_idx == IDX_MAX) ? '0 : arb_idx + 1'b1;

            // Simultaneous push and pop leave occupancy unchanged.
            if (push && !pop && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            else if (pop && !push && cnt != '0)
                cnt <= cnt - 1'b1;

            case (state)
                RUN: begin
                    if (bus.flush)
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (bus.fifo_empty) begin
                        state      <= RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed bench for fifo_push_arbiter (WIDTH=8,
// DEPTH=4, NREQ=4). FIFO status inputs are driven by hand to match the
// occupancy each step should produce.
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.WIDTH(8), .DEPTH(4), .NREQ(4)) bus ();

    fifo_push_arbiter #(.WIDTH(8), .DEPTH(4), .NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic pr, input logic fl,
                         input logic full, input logic empty);
        bus.req        = r;
        bus.pop_req    = pr;
        bus.flush      = fl;
        bus.fifo_full  = full;
        bus.fifo_empty = empty;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst          = 1'b1;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        drive(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        #1;
        check("rst_gnt",   32'(bus.gnt), 32'h0);
        check("rst_push",  32'(bus.fifo_push), 32'h0);
        check("rst_cnt",   32'(bus.cnt), 32'h0);
        check("rst_err",   32'(bus.status_err), 32'h0);
        check("rst_state", 32'(bus.state), 32'(RUN));

        // Fairness: all request, consumer pops every cycle.
        rst = 1'b0;
        drive(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check("fair0_gnt",  32'(bus.gnt), 32'h1);
        check("fair0_data", 32'(bus.fifo_data_in), 32'h11);
        check("fair0_pop",  32'(bus.fifo_pop), 32'h0);
        tick();
        check("fair0_cnt",  32'(bus.cnt), 32'h1);
        drive(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("fair1_gnt",  32'(bus.gnt), 32'h2);
        check("fair1_data", 32'(bus.fifo_data_in), 32'h22);
        check("fair1_pop",  32'(bus.fifo_pop), 32'h1);
        tick();
        #1;
        check("fair2_gnt",  32'(bus.gnt), 32'h4);
        check("fair2_data", 32'(bus.fifo_data_in), 32'h33);
        tick();
        #1;
        check("fair3_gnt",  32'(bus.gnt), 32'h8);
        check("fair3_data", 32'(bus.fifo_data_in), 32'h44);
        tick();
        #1;
        check("fair4_gnt",  32'(bus.gnt), 32'h1);
        tick();
        check("fair_cnt",   32'(bus.cnt), 32'h1);

        // Pop only, no requests.
        drive(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("idle_gnt",  32'(bus.gnt), 32'h0);
        check("idle_data", 32'(bus.fifo_data_in), 32'h0);
        check("idle_push", 32'(bus.fifo_push), 32'h0);
        check("idle_pop",  32'(bus.fifo_pop), 32'h1);
        tick();
        check("idle_cnt",  32'(bus.cnt), 32'h0);

        // Wrap-around search: ptr=1, req=1001 -> requester 3.
        drive(4'b1001, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("wrap_gnt",  32'(bus.gnt), 32'h8);
        check("wrap_data", 32'(bus.fifo_data_in), 32'h44);
        tick();
        drive(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("fill2_gnt", 32'(bus.gnt), 32'h4);
        tick();
        drive(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("fill3_gnt", 32'(bus.gnt), 32'h1);
        tick();
        #1;
        check("fill4_gnt", 32'(bus.gnt), 32'h2);
        tick();
        check("full_cnt",  32'(bus.cnt), 32'h4);

        // Full: push blocked, pop proceeds.
        drive(4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("full_push", 32'(bus.fifo_push), 32'h0);
        check("full_gnt",  32'(bus.gnt), 32'h0);
        check("full_data", 32'(bus.fifo_data_in), 32'h0);
        check("full_pop",  32'(bus.fifo_pop), 32'h1);
        tick();
        check("full_cnt3", 32'(bus.cnt), 32'h3);
        check("full_err",  32'(bus.status_err), 32'h0);

        // Flush with three entries held.
        drive(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fl_state", 32'(bus.state), 32'(FLUSH));
        check("fl_cnt",   32'(bus.cnt), 32'h3);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fl_gnt",  32'(bus.gnt), 32'h0);
            check("fl_push", 32'(bus.fifo_push), 32'h0);
            check("fl_pop",  32'(bus.fifo_pop), 32'h1);
            check("fl_done", 32'(bus.flush_done), 32'h0);
            tick();
        end
        check("fl_cnt0", 32'(bus.cnt), 32'h0);
        drive(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("fl_last_pop",   32'(bus.fifo_pop), 32'h0);
        check("fl_last_gnt",   32'(bus.gnt), 32'h0);
        check("fl_last_state", 32'(bus.state), 32'(FLUSH));
        tick();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fl_done1", 32'(bus.flush_done), 32'h1);
        check("fl_run",   32'(bus.state), 32'(RUN));
        tick();
        check("fl_done0", 32'(bus.flush_done), 32'h0);

        // Flush together with a push: the RUN-cycle push goes through.
        drive(4'b0010, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        check("fp_push", 32'(bus.fifo_push), 32'h1);
        check("fp_gnt",  32'(bus.gnt), 32'h2);
        check("fp_data", 32'(bus.fifo_data_in), 32'h22);
        tick();
        drive(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("fp_state", 32'(bus.state), 32'(FLUSH));
        check("fp_cnt",   32'(bus.cnt), 32'h1);
        check("fp_gnt2",  32'(bus.gnt), 32'h0);
        check("fp_pop",   32'(bus.fifo_pop), 32'h1);
        tick();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fp_cnt0",  32'(bus.cnt), 32'h0);
        check("fp_state2", 32'(bus.state), 32'(FLUSH));
        tick();
        check("fp_done", 32'(bus.flush_done), 32'h1);
        check("fp_run",  32'(bus.state), 32'(RUN));

        // Status error: FIFO reports non-empty while cnt is 0.
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("err_set", 32'(bus.status_err), 32'h1);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        check("err_hold", 32'(bus.status_err), 32'h1);

        // Reset in the middle of a flush with two entries held.
        drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("mf_gnt1", 32'(bus.gnt), 32'h1);
        tick();
        drive(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("mf_gnt2", 32'(bus.gnt), 32'h1);
        tick();
        check("mf_cnt2", 32'(bus.cnt), 32'h2);
        drive(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mf_state", 32'(bus.state), 32'(FLUSH));
        #2;
        rst = 1'b1;
        #1;
        check("mf_rst_state", 32'(bus.state), 32'(RUN));
        check("mf_rst_cnt",   32'(bus.cnt), 32'h0);
        check("mf_rst_err",   32'(bus.status_err), 32'h0);
        check("mf_rst_done",  32'(bus.flush_done), 32'h0);
        check("mf_rst_gnt",   32'(bus.gnt), 32'h0);
        check("mf_rst_push",  32'(bus.fifo_push), 32'h0);
        tick();
        rst = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("mf_done_a",  32'(bus.flush_done), 32'h0);
        check("mf_state_a", 32'(bus.state), 32'(RUN));
        tick();
        check("mf_done_b",  32'(bus.flush_done), 32'h0);
        check("mf_cnt_b",   32'(bus.cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
